// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Shares the single Avalon-MM master port of the SDRAM controller between
//   two requesters: port 0 = VGA scanout reader, port 1 = HPS pixel writer.
//   One transfer is granted at a time, with one idle cycle between transfers.
//   Outstanding pipelined reads are tracked in a small return-ID FIFO so that
//   each m_readdatavalid is steered back to the port that issued the read.
//
// Ports
//   clk, reset                 system clock, asynchronous active-high reset
//   s{0,1}_address/read/write/writedata/byteenable   requester command
//   s{0,1}_waitrequest         1 = request not accepted this cycle
//   s{0,1}_readdata/readdatavalid                    read return
//   m_address/read/write/writedata/byteenable        command to controller
//   m_waitrequest, m_readdata, m_readdatavalid        controller response
//   orphan_err                 sticky: read return arrived with no read pending
//
// Configuration
//   SDRAM_ARB_FIXED_PRIO_EN    when defined, port 0 always wins arbitration in
//                              IDLE (port 1 may starve); default is round robin.

module sdram_port_arbiter #(
  parameter int ADDR_W      = 25,
  parameter int DATA_W      = 16,
  parameter int MAX_PENDING = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   s0_address,
  input  logic                s0_read,
  input  logic                s0_write,
  input  logic [DATA_W-1:0]   s0_writedata,
  input  logic [DATA_W/8-1:0] s0_byteenable,
  output logic                s0_waitrequest,
  output logic [DATA_W-1:0]   s0_readdata,
  output logic                s0_readdatavalid,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W-1:0]   s1_writedata,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  output logic                s1_waitrequest,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  output logic [DATA_W/8-1:0] m_byteenable,
  input  logic                m_waitrequest,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_readdatavalid,
  output logic                orphan_err
);

  localparam int PTR_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
  localparam int CNT_W = $clog2(MAX_PENDING + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t           state;
  logic             last_grant;
  logic [CNT_W-1:0] pending;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             fifo_id [MAX_PENDING];

  logic reads_full;
  logic elig0;
  logic elig1;
  logic grant0;
  logic accept;
  logic push;
  logic pop;
  logic head_id;

  // Command path: owner's fields pass straight through; read wins over write
  always_comb begin
    m_address      = '0;
    m_read         = 1'b0;
    m_write        = 1'b0;
    m_writedata    = '0;
    m_byteenable   = '0;
    s0_waitrequest = 1'b1;
    s1_waitrequest = 1'b1;
    case (state)
      OWN0: begin
        m_address      = s0_address;
        m_read         = s0_read;
        m_write        = s0_write & ~s0_read;
        m_writedata    = s0_writedata;
        m_byteenable   = s0_byteenable;
        s0_waitrequest = m_waitrequest;
      end
      OWN1: begin
        m_address      = s1_address;
        m_read         = s1_read;
        m_write        = s1_write & ~s1_read;
        m_writedata    = s1_writedata;
        m_byteenable   = s1_byteenable;
        s1_waitrequest = m_waitrequest;
      end
      default: ;
    endcase
  end

  assign reads_full = (pending == CNT_W'(MAX_PENDING));
  assign elig0      = s0_write | (s0_read & ~reads_full);
  assign elig1      = s1_write | (s1_read & ~reads_full);

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  assign grant0 = elig0;
`else
  // Contention goes to the port that did not win last time
  assign grant0 = (elig0 & elig1) ? last_grant : elig0;
`endif

  assign accept = (state != IDLE) & (m_read | m_write) & ~m_waitrequest;
  assign push   = accept & m_read;
  // A return with nothing outstanding is dropped rather than popping a stale ID
  assign pop    = m_readdatavalid & (pending != '0);
  assign head_id = fifo_id[rd_ptr];

  // Return path: steer the strobe by the oldest outstanding ID
  assign s0_readdata      = m_readdata;
  assign s1_readdata      = m_readdata;
  assign s0_readdatavalid = pop & ~head_id;
  assign s1_readdatavalid = pop &  head_id;

  // Arbitration FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (elig0 | elig1) begin
            state      <= grant0 ? OWN0 : OWN1;
            last_grant <= ~grant0;
          end
        end
        // Leave on accept, or at once if the owner withdrew its request
        default: begin
          if (!(m_read | m_write) || !m_waitrequest) state <= IDLE;
        end
      endcase
    end
  end

  // Outstanding-read bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      orphan_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: ;
      endcase
      if (m_readdatavalid && pending == '0) orphan_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_id[wr_ptr] <= (state == OWN1);
  end

  a_rw_excl0: assert property (@(posedge clk) disable iff (reset) !(s0_read && s0_write))
    else $error("port 0 asserted read and write together");
  a_rw_excl1: assert property (@(posedge clk) disable iff (reset) !(s1_read && s1_write))
    else $error("port 1 asserted read and write together");

endmodule

// File: tb/tb_sdram_port_arbiter.sv
module tb_sdram_port_arbiter;

  logic        clk;
  logic        reset;
  logic [24:0] s0_address, s1_address, m_address;
  logic        s0_read, s0_write, s1_read, s1_write;
  logic [15:0] s0_writedata, s1_writedata, m_writedata;
  logic [1:0]  s0_byteenable, s1_byteenable, m_byteenable;
  logic        s0_waitrequest, s1_waitrequest;
  logic [15:0] s0_readdata, s1_readdata, m_readdata;
  logic        s0_readdatavalid, s1_readdatavalid;
  logic        m_read, m_write, m_waitrequest, m_readdatavalid;
  logic        orphan_err;

  int n_checks = 0;
  int n_errors = 0;

  sdram_port_arbiter #(.ADDR_W(25), .DATA_W(16), .MAX_PENDING(8)) dut (
    .clk(clk), .reset(reset),
    .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write),
    .s0_writedata(s0_writedata), .s0_byteenable(s0_byteenable),
    .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata),
    .s0_readdatavalid(s0_readdatavalid),
    .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write),
    .s1_writedata(s1_writedata), .s1_byteenable(s1_byteenable),
    .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata),
    .s1_readdatavalid(s1_readdatavalid),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid), .orphan_err(orphan_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic rd, input logic wr,
                       input logic [24:0] a, input logic [15:0] d);
    if (p == 0) begin
      s0_read = rd; s0_write = wr; s0_address = a; s0_writedata = d; s0_byteenable = 2'b11;
    end else begin
      s1_read = rd; s1_write = wr; s1_address = a; s1_writedata = d; s1_byteenable = 2'b11;
    end
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  // Issue one transfer on port p, waiting a bounded time for the grant
  task automatic xfer(input int p, input logic rd, input logic [24:0] a, input logic [15:0] d);
    logic got;
    got = 1'b0;
    drive(p, rd, ~rd, a, d);
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if ((p == 0 ? s0_waitrequest : s1_waitrequest) == 1'b0) got = 1'b1;
      step();
    end
    chk($sformatf("xfer_grant_p%0d", p), {31'd0, got}, 32'd1);
    drive(p, 1'b0, 1'b0, '0, '0);
  endtask

  // One controller read return; checks which port receives it
  task automatic ret(input logic [15:0] d, input int exp_port);
    m_readdatavalid = 1'b1;
    m_readdata = d;
    #1;
    chk("ret_rdv0", {31'd0, s0_readdatavalid}, {31'd0, exp_port == 0});
    chk("ret_rdv1", {31'd0, s1_readdatavalid}, {31'd0, exp_port == 1});
    chk("ret_data", {16'd0, exp_port == 0 ? s0_readdata : s1_readdata}, {16'd0, d});
    step();
    m_readdatavalid = 1'b0;
  endtask

  initial begin
    logic [1:0] grants [8];
    int ng;
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    m_waitrequest = 1'b0; m_readdata = '0; m_readdatavalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_wait0", {31'd0, s0_waitrequest}, 32'd1);
    chk("rst_wait1", {31'd0, s1_waitrequest}, 32'd1);
    chk("rst_mrw", {30'd0, m_read, m_write}, 32'd0);
    chk("rst_rdv", {30'd0, s0_readdatavalid, s1_readdatavalid}, 32'd0);
    chk("rst_orphan", {31'd0, orphan_err}, 32'd0);
    reset = 1'b0;
    step();

    // Single write on port 1
    s1_write = 1'b1; s1_address = 25'h0001234; s1_writedata = 16'hBEEF; s1_byteenable = 2'b11;
    #1;
    chk("w_idle_mwrite", {31'd0, m_write}, 32'd0);
    chk("w_idle_wait1", {31'd0, s1_waitrequest}, 32'd1);
    step();
    chk("w_own_mwrite", {31'd0, m_write}, 32'd1);
    chk("w_own_addr", {7'd0, m_address}, 32'h0001234);
    chk("w_own_data", {16'd0, m_writedata}, 32'hBEEF);
    chk("w_own_be", {30'd0, m_byteenable}, 32'd3);
    chk("w_own_wait1", {31'd0, s1_waitrequest}, 32'd0);
    chk("w_own_wait0", {31'd0, s0_waitrequest}, 32'd1);
    step();
    s1_write = 1'b0;
    #1;
    chk("w_after_wait1", {31'd0, s1_waitrequest}, 32'd1);
    chk("w_after_mwrite", {31'd0, m_write}, 32'd0);

    // Continuous reads on both ports: grant order
    reset_dut();
    s0_read = 1'b1; s1_read = 1'b1;
    ng = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (!s0_waitrequest) begin grants[ng] = 2'd0; ng++; end
      else if (!s1_waitrequest) begin grants[ng] = 2'd1; ng++; end
      step();
    end
    s0_read = 1'b0; s1_read = 1'b0;
    chk("rr_count", ng, 32'd4);
    for (int i = 0; i < 4; i++) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
      chk($sformatf("grant_%0d", i), {30'd0, grants[i]}, 32'd0);
`else
      chk($sformatf("grant_%0d", i), {30'd0, grants[i]}, i % 2);
`endif
    end

    // Read returns routed by issue order: 0,1,1,0
    reset_dut();
    xfer(0, 1'b1, 25'h10, '0);
    xfer(1, 1'b1, 25'h20, '0);
    xfer(1, 1'b1, 25'h30, '0);
    xfer(0, 1'b1, 25'h40, '0);
    chk("pend_4", dut.pending, 32'd4);
    ret(16'hAAAA, 0);
    ret(16'hBBBB, 1);
    ret(16'hCCCC, 1);
    ret(16'hDDDD, 0);
    chk("pend_0", dut.pending, 32'd0);
    chk("ret_orphan", {31'd0, orphan_err}, 32'd0);

    // Eight outstanding reads: ninth held, write on other port still served
    reset_dut();
    for (int i = 0; i < 8; i++) xfer(0, 1'b1, 25'(i), '0);
    chk("pend_8", dut.pending, 32'd8);
    drive(0, 1'b1, 1'b0, 25'h99, '0);
    drive(1, 1'b0, 1'b1, 25'h55, 16'h1234);
    #1;
    chk("full_x0_wait0", {31'd0, s0_waitrequest}, 32'd1);
    step();
    chk("full_x1_wait1", {31'd0, s1_waitrequest}, 32'd0);
    chk("full_x1_wait0", {31'd0, s0_waitrequest}, 32'd1);
    chk("full_x1_mwrite", {31'd0, m_write}, 32'd1);
    step();
    drive(1, 1'b0, 1'b0, '0, '0);
    #1;
    chk("full_x2_wait0", {31'd0, s0_waitrequest}, 32'd1);
    step();
    m_readdatavalid = 1'b1; m_readdata = 16'h5555;
    #1;
    chk("full_x3_wait0", {31'd0, s0_waitrequest}, 32'd1);
    chk("full_x3_rdv0", {31'd0, s0_readdatavalid}, 32'd1);
    step();
    m_readdatavalid = 1'b0;
    #1;
    chk("full_x4_wait0", {31'd0, s0_waitrequest}, 32'd1);
    step();
    chk("full_x5_wait0", {31'd0, s0_waitrequest}, 32'd0);
    chk("full_x5_mread", {31'd0, m_read}, 32'd1);
    chk("full_x5_addr", {7'd0, m_address}, 32'h99);
    step();
    drive(0, 1'b0, 1'b0, '0, '0);

    // Controller stall for 5 cycles while port 0 owns the bus
    reset_dut();
    m_waitrequest = 1'b1;
    drive(0, 1'b0, 1'b1, 25'h100, 16'h1111);
    drive(1, 1'b0, 1'b1, 25'h200, 16'h2222);
    #1;
    chk("stall_idle_wait0", {31'd0, s0_waitrequest}, 32'd1);
    step();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall%0d_mwrite", i), {31'd0, m_write}, 32'd1);
      chk($sformatf("stall%0d_addr", i), {7'd0, m_address}, 32'h100);
      chk($sformatf("stall%0d_data", i), {16'd0, m_writedata}, 32'h1111);
      chk($sformatf("stall%0d_wait0", i), {31'd0, s0_waitrequest}, 32'd1);
      chk($sformatf("stall%0d_wait1", i), {31'd0, s1_waitrequest}, 32'd1);
      step();
    end
    m_waitrequest = 1'b0;
    #1;
    chk("stall_acc_wait0", {31'd0, s0_waitrequest}, 32'd0);
    chk("stall_acc_wait1", {31'd0, s1_waitrequest}, 32'd1);
    step();
    drive(0, 1'b0, 1'b0, '0, '0);
    #1;
    chk("stall_bubble_wait1", {31'd0, s1_waitrequest}, 32'd1);
    step();
    chk("stall_own1_wait1", {31'd0, s1_waitrequest}, 32'd0);
    chk("stall_own1_addr", {7'd0, m_address}, 32'h200);
    step();
    drive(1, 1'b0, 1'b0, '0, '0);

    // Orphan return, then asynchronous reset mid-OWN1
    reset_dut();
    m_readdatavalid = 1'b1; m_readdata = 16'h7777;
    #1;
    chk("orph_rdv", {30'd0, s0_readdatavalid, s1_readdatavalid}, 32'd0);
    chk("orph_before", {31'd0, orphan_err}, 32'd0);
    step();
    m_readdatavalid = 1'b0;
    #1;
    chk("orph_set", {31'd0, orphan_err}, 32'd1);
    m_waitrequest = 1'b1;
    step();
    drive(1, 1'b0, 1'b1, 25'h300, 16'h3333);
    step();
    chk("own1_mwrite", {31'd0, m_write}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_mwrite", {31'd0, m_write}, 32'd0);
    chk("async_orphan", {31'd0, orphan_err}, 32'd0);
    chk("async_wait1", {31'd0, s1_waitrequest}, 32'd1);
    step();
    drive(1, 1'b0, 1'b0, '0, '0);
    reset = 1'b0;
    m_waitrequest = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
